apuracao_votos: RTL and testbench

- Parametrised vote-tally unit for the day/voting phase of the werewolf game.
- Collects one vote per living player, then scans the tallies sequentially and reports the eliminated player, a tie, or "no elimination".
- Sits between the player-selection converter and the control unit.
- Generalises the fixed 5-player flow to N_JOGADORES players.
- Adds skip votes, duplicate and dead-voter rejection, and forced early close.

---
 rtl/apuracao_votos.sv | 199 +++++++++++++++++++
 tb/tb_apuracao_votos.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apuracao_votos.sv
// ---------------------------------------------------------------------------
// apuracao_votos: vote tally unit for the day phase of the werewolf game.
// It collects one vote per living player, then scans the tallies one player
// per cycle and reports the eliminated player, a tie, or "no elimination".
//
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-low reset
//   iniciar            pulse: open a new round (only honoured in OCIOSO/RESULTADO)
//   vivos              alive mask, bit i-1 = player i; sampled on iniciar
//   voto_valido        strobe qualifying votante/voto
//   votante, voto      voter ID (1..N) and target ID (0 = skip, 1..N)
//   encerrar           force the end of collection
//   coletando          high while collecting votes
//   voto_aceito        pulse, the cycle after an accepted strobe
//   pronto             pulse on the first RESULTADO cycle
//   tem_eliminado      a unique player was eliminated
//   eliminado          eliminated ID (0 when none)
//   empate             tie at the top player count
//   votos_pular        final skip count
//   db_estado          state code (0 OCIOSO, 1 COLETA, 2 APURA, 3 RESULTADO)
// ---------------------------------------------------------------------------
module apuracao_votos #(
    parameter int unsigned N_JOGADORES = 5,
    parameter int unsigned ID_W        = 3,
    parameter int unsigned CNT_W       = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   voto_valido,
    input  logic [ID_W-1:0]        votante,
    input  logic [ID_W-1:0]        voto,
    input  logic                   encerrar,
    output logic                   coletando,
    output logic                   voto_aceito,
    output logic                   pronto,
    output logic                   tem_eliminado,
    output logic [ID_W-1:0]        eliminado,
    output logic                   empate,
    output logic [CNT_W-1:0]       votos_pular,
    output logic [1:0]             db_estado
);

    localparam int N = N_JOGADORES;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        COLETA    = 2'd1,
        APURA     = 2'd2,
        RESULTADO = 2'd3
    } estado_t;

    estado_t          r_estado;
    logic [N-1:0]     r_vivos;
    logic [N-1:0]     r_ja_votou;
    logic [CNT_W-1:0] r_tally [0:N];  // index 0 holds the skip votes
    logic [ID_W-1:0]  r_k;            // candidate being scanned in APURA
    logic [CNT_W-1:0] r_max;
    logic [ID_W-1:0]  r_arg;
    logic             r_tie;
    logic             r_voto_aceito;
    logic             r_pronto;
    logic             r_tem_eliminado;
    logic [ID_W-1:0]  r_eliminado;
    logic             r_empate;
    logic [CNT_W-1:0] r_votos_pular;

    logic [N-1:0]     w_votante_oh;
    logic             w_voto_ok;
    logic             w_aceita;
    logic [N-1:0]     w_ja_votou_nx;
    logic [CNT_W-1:0] w_tally_k;
    logic [CNT_W-1:0] w_max_nx;
    logic [ID_W-1:0]  w_arg_nx;
    logic             w_tie_nx;
    logic             w_elim_ok;

    // Vote validation. Out-of-range IDs simply never match a player, so they
    // leave the one-hot empty and the strobe is dropped.
    always_comb begin
        w_votante_oh = '0;
        w_voto_ok    = (voto == '0);
        for (int i = 1; i <= N; i++) begin
            if (votante == ID_W'(i)) begin
                w_votante_oh[i-1] = 1'b1;
            end
            if (voto == ID_W'(i) && r_vivos[i-1]) begin
                w_voto_ok = 1'b1;
            end
        end
        w_aceita = (r_estado == COLETA) && voto_valido && w_voto_ok &&
                   (|(w_votante_oh & r_vivos & ~r_ja_votou));
        w_ja_votou_nx = r_ja_votou | (w_aceita ? w_votante_oh : '0);
    end

    // One step of the running max / argmax / tie scan.
    always_comb begin
        w_tally_k = '0;
        for (int i = 1; i <= N; i++) begin
            if (r_k == ID_W'(i)) begin
                w_tally_k = r_tally[i];
            end
        end
        w_max_nx = r_max;
        w_arg_nx = r_arg;
        w_tie_nx = r_tie;
        if (w_tally_k > r_max) begin
            w_max_nx = w_tally_k;
            w_arg_nx = r_k;
            w_tie_nx = 1'b0;
        end else if (w_tally_k == r_max && r_max != '0) begin
            w_tie_nx = 1'b1;
        end
        // A top count equal to the skip count does not eliminate anyone.
        w_elim_ok = (w_max_nx != '0) && !w_tie_nx && (w_max_nx > r_tally[0]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado        <= OCIOSO;
            r_vivos         <= '0;
            r_ja_votou      <= '0;
            for (int i = 0; i <= N; i++) begin
                r_tally[i] <= '0;
            end
            r_k             <= '0;
            r_max           <= '0;
            r_arg           <= '0;
            r_tie           <= 1'b0;
            r_voto_aceito   <= 1'b0;
            r_pronto        <= 1'b0;
            r_tem_eliminado <= 1'b0;
            r_eliminado     <= '0;
            r_empate        <= 1'b0;
            r_votos_pular   <= '0;
        end else begin
            r_voto_aceito <= w_aceita;
            r_pronto      <= 1'b0;
            case (r_estado)
                OCIOSO, RESULTADO: begin
                    if (iniciar) begin
                        r_vivos         <= vivos;
                        r_ja_votou      <= '0;
                        for (int i = 0; i <= N; i++) begin
                            r_tally[i] <= '0;
                        end
                        r_k             <= ID_W'(1);
                        r_max           <= '0;
                        r_arg           <= '0;
                        r_tie           <= 1'b0;
                        r_tem_eliminado <= 1'b0;
                        r_eliminado     <= '0;
                        r_empate        <= 1'b0;
                        r_votos_pular   <= '0;
                        r_estado        <= COLETA;
                    end
                end
                COLETA: begin
                    for (int i = 0; i <= N; i++) begin
                        if (w_aceita && voto == ID_W'(i)) begin
                            r_tally[i] <= r_tally[i] + CNT_W'(1);
                        end
                    end
                    r_ja_votou <= w_ja_votou_nx;
                    // An empty alive mask matches immediately and closes at once.
                    if (w_ja_votou_nx == r_vivos || encerrar) begin
                        r_estado <= APURA;
                    end
                end
                APURA: begin
                    r_max <= w_max_nx;
                    r_arg <= w_arg_nx;
                    r_tie <= w_tie_nx;
                    r_k   <= r_k + ID_W'(1);
                    if (r_k == ID_W'(N)) begin
                        r_tem_eliminado <= w_elim_ok;
                        r_eliminado     <= w_elim_ok ? w_arg_nx : '0;
                        r_empate        <= w_tie_nx;
                        r_votos_pular   <= r_tally[0];
                        r_pronto        <= 1'b1;
                        r_estado        <= RESULTADO;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign coletando     = (r_estado == COLETA);
    assign voto_aceito   = r_voto_aceito;
    assign pronto        = r_pronto;
    assign tem_eliminado = r_tem_eliminado;
    assign eliminado     = r_eliminado;
    assign empate        = r_empate;
    assign votos_pular   = r_votos_pular;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_apuracao_votos.sv
// ---------------------------------------------------------------------------
// tb_apuracao_votos: self-checking bench for apuracao_votos (N=5).
// Table of full rounds with constant expectations, hand-written corner
// sequences, and random rounds checked against a vote-counting model.
// ---------------------------------------------------------------------------
module tb_apuracao_votos;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iniciar = 1'b0;
    logic [N-1:0]  vivos = '0;
    logic          voto_valido = 1'b0;
    logic [IW-1:0] votante = '0;
    logic [IW-1:0] voto = '0;
    logic          encerrar = 1'b0;
    logic          coletando, voto_aceito, pronto, tem_eliminado, empate;
    logic [IW-1:0] eliminado;
    logic [CW-1:0] votos_pular;
    logic [1:0]    db_estado;

    apuracao_votos #(.N_JOGADORES(N), .ID_W(IW), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .vivos        (vivos),
        .voto_valido  (voto_valido),
        .votante      (votante),
        .voto         (voto),
        .encerrar     (encerrar),
        .coletando    (coletando),
        .voto_aceito  (voto_aceito),
        .pronto       (pronto),
        .tem_eliminado(tem_eliminado),
        .eliminado    (eliminado),
        .empate       (empate),
        .votos_pular  (votos_pular),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: who is alive, who has voted, votes per target (0 = skip).
    bit m_vivos [8];
    bit m_voted [8];
    int m_tally [8];

    typedef struct packed {
        logic [4:0]      viv;
        int              n;
        logic [0:5][5:0] v;     // each entry is {votante, voto}, written in octal
        logic            tem;
        logic [2:0]      elim;
        logic            emp;
        logic [2:0]      skip;
    } rec_t;

    rec_t tab [8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic start_round(input logic [4:0] v);
        iniciar = 1'b1;
        vivos   = v;
        @(negedge clock);
        iniciar = 1'b0;
        for (int p = 0; p < 8; p++) begin
            m_voted[p] = 1'b0;
            m_tally[p] = 0;
            if (p >= 1 && p <= N) m_vivos[p] = v[p-1];
            else                  m_vivos[p] = 1'b0;
        end
        chk("coletando_inicio", int'(coletando), 1);
        chk("eliminado_limpo", int'(eliminado), 0);
    endtask

    // One cycle of stimulus; returns whether collection is expected to close.
    task automatic send(input bit vld, input int vt, input int vo, input bit enc,
                        output bit closed);
        bit acc;
        bit all_voted;
        acc = vld && m_vivos[vt] && !m_voted[vt] && (vo == 0 || m_vivos[vo]);
        voto_valido = vld;
        votante     = 3'(vt);
        voto        = 3'(vo);
        encerrar    = enc;
        @(negedge clock);
        voto_valido = 1'b0;
        encerrar    = 1'b0;
        if (acc) begin
            m_tally[vo]++;
            m_voted[vt] = 1'b1;
        end
        all_voted = 1'b1;
        for (int p = 1; p <= N; p++) begin
            if (m_voted[p] != m_vivos[p]) all_voted = 1'b0;
        end
        closed = enc || all_voted;
        chk("voto_aceito", int'(voto_aceito), int'(acc));
        chk("estado_apos_voto", int'(db_estado), closed ? 2 : 1);
    endtask

    task automatic model_result(output bit tem, output int elim, output bit emp,
                                output int skip);
        int top;
        int n_top;
        top = 0;
        for (int p = 1; p <= N; p++) if (m_tally[p] > top) top = m_tally[p];
        n_top = 0;
        elim  = 0;
        for (int p = 1; p <= N; p++) begin
            if (top > 0 && m_tally[p] == top) begin
                n_top++;
                elim = p;
            end
        end
        emp  = (n_top > 1);
        skip = m_tally[0];
        tem  = (n_top == 1) && (top > skip);
        if (!tem) elim = 0;
    endtask

    // Called at the negedge of the first APURA cycle.
    task automatic wait_result(input bit tem, input int elim, input bit emp, input int skip);
        int cyc;
        cyc = 0;
        while (pronto !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("latencia_pronto", cyc, N);
        chk("estado_resultado", int'(db_estado), 3);
        chk("tem_eliminado", int'(tem_eliminado), int'(tem));
        chk("eliminado", int'(eliminado), elim);
        chk("empate", int'(empate), int'(emp));
        chk("votos_pular", int'(votos_pular), skip);
        @(negedge clock);
        chk("pronto_um_ciclo", int'(pronto), 0);
        chk("eliminado_mantido", int'(eliminado), elim);
        chk("estado_mantido", int'(db_estado), 3);
    endtask

    initial begin
        bit c;
        bit m_tem;
        bit m_emp;
        int m_elim;
        int m_skip;
        int seen;

        tab[0] = '{viv: 5'b11111, n: 5, v: {6'o13, 6'o23, 6'o31, 6'o43, 6'o50, 6'o00},
                   tem: 1'b1, elim: 3'd3, emp: 1'b0, skip: 3'd1};
        tab[1] = '{viv: 5'b01111, n: 4, v: {6'o12, 6'o21, 6'o32, 6'o41, 6'o00, 6'o00},
                   tem: 1'b0, elim: 3'd0, emp: 1'b1, skip: 3'd0};
        tab[2] = '{viv: 5'b00111, n: 3, v: {6'o10, 6'o20, 6'o32, 6'o00, 6'o00, 6'o00},
                   tem: 1'b0, elim: 3'd0, emp: 1'b0, skip: 3'd2};
        tab[3] = '{viv: 5'b00011, n: 2, v: {6'o12, 6'o20, 6'o00, 6'o00, 6'o00, 6'o00},
                   tem: 1'b0, elim: 3'd0, emp: 1'b0, skip: 3'd1};
        tab[4] = '{viv: 5'b00000, n: 0, v: {6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00},
                   tem: 1'b0, elim: 3'd0, emp: 1'b0, skip: 3'd0};
        tab[5] = '{viv: 5'b10001, n: 2, v: {6'o51, 6'o11, 6'o00, 6'o00, 6'o00, 6'o00},
                   tem: 1'b1, elim: 3'd1, emp: 1'b0, skip: 3'd0};
        tab[6] = '{viv: 5'b11111, n: 5, v: {6'o15, 6'o25, 6'o34, 6'o44, 6'o55, 6'o00},
                   tem: 1'b1, elim: 3'd5, emp: 1'b0, skip: 3'd0};
        tab[7] = '{viv: 5'b11111, n: 5, v: {6'o11, 6'o22, 6'o33, 6'o40, 6'o50, 6'o00},
                   tem: 1'b0, elim: 3'd0, emp: 1'b1, skip: 3'd2};

        // Reset state.
        repeat (2) @(negedge clock);
        chk("reset_estado", int'(db_estado), 0);
        chk("reset_coletando", int'(coletando), 0);
        chk("reset_pronto", int'(pronto), 0);
        chk("reset_tem", int'(tem_eliminado), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("ocioso_apos_reset", int'(db_estado), 0);

        // Table of complete rounds.
        for (int i = 0; i < 8; i++) begin
            start_round(tab[i].viv);
            if (tab[i].n == 0) begin
                @(negedge clock);
                chk("vazio_fecha", int'(db_estado), 2);
            end
            for (int j = 0; j < tab[i].n; j++) begin
                send(1'b1, int'(tab[i].v[j][5:3]), int'(tab[i].v[j][2:0]), 1'b0, c);
            end
            wait_result(tab[i].tem, int'(tab[i].elim), tab[i].emp, int'(tab[i].skip));
        end

        // Invalid strobes and an ignored iniciar during collection.
        start_round(5'b11011);
        send(1'b1, 1, 2, 1'b0, c);
        send(1'b1, 3, 1, 1'b0, c);   // dead voter
        send(1'b1, 2, 3, 1'b0, c);   // dead target
        send(1'b1, 1, 4, 1'b0, c);   // repeat voter
        send(1'b1, 0, 1, 1'b0, c);   // voter 0
        send(1'b1, 6, 1, 1'b0, c);   // voter out of range
        send(1'b1, 2, 6, 1'b0, c);   // target out of range
        iniciar = 1'b1;
        vivos   = 5'b00001;
        @(negedge clock);
        iniciar = 1'b0;
        chk("iniciar_ignorado", int'(db_estado), 1);
        send(1'b1, 2, 1, 1'b0, c);
        send(1'b1, 4, 1, 1'b0, c);
        send(1'b1, 5, 0, 1'b0, c);
        wait_result(1'b1, 1, 1'b0, 1);

        // Forced close after two votes.
        start_round(5'b11111);
        send(1'b1, 1, 4, 1'b0, c);
        send(1'b1, 2, 4, 1'b0, c);
        send(1'b0, 0, 0, 1'b1, c);
        wait_result(1'b1, 4, 1'b0, 0);

        // Forced close coinciding with a valid vote: that vote still counts.
        start_round(5'b11111);
        send(1'b1, 3, 2, 1'b0, c);
        send(1'b1, 1, 2, 1'b1, c);
        wait_result(1'b1, 2, 1'b0, 0);

        // Reset in the middle of APURA aborts the round.
        start_round(5'b11111);
        for (int j = 1; j <= N; j++) send(1'b1, j, 1, 1'b0, c);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("reset_apura_estado", int'(db_estado), 0);
        chk("reset_apura_aceito", int'(voto_aceito), 0);
        chk("reset_apura_elim", int'(eliminado), 0);
        chk("reset_apura_pular", int'(votos_pular), 0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (pronto) seen++;
        end
        chk("sem_pronto_apos_reset", seen, 0);
        chk("ocioso_apos_aborto", int'(db_estado), 0);
        start_round(5'b00011);
        send(1'b1, 1, 2, 1'b0, c);
        send(1'b1, 2, 2, 1'b0, c);
        wait_result(1'b1, 2, 1'b0, 0);

        // Random rounds against the model.
        for (int r = 0; r < 40; r++) begin
            int n;
            start_round(5'($urandom_range(0, 31)));
            c = 1'b0;
            n = 0;
            if (m_vivos[1] | m_vivos[2] | m_vivos[3] | m_vivos[4] | m_vivos[5]) begin
                while (!c) begin
                    bit vld;
                    bit enc;
                    int vt;
                    int vo;
                    vld = ($urandom_range(0, 3) != 0);
                    enc = (n >= 40) || ($urandom_range(0, 15) == 0);
                    vt  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, N))
                                                      : int'($urandom_range(0, 7));
                    vo  = int'($urandom_range(0, 7));
                    send(vld, vt, vo, enc, c);
                    n++;
                end
            end else begin
                @(negedge clock);
                chk("vazio_fecha_rand", int'(db_estado), 2);
            end
            model_result(m_tem, m_elim, m_emp, m_skip);
            wait_result(m_tem, m_elim, m_emp, m_skip);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
